cdb_arbiter: RTL
================

# cdb_arbiter

Allocates the `NUM_CDB` common data bus ports each cycle among all functional-unit result requesters: ALU, branch and memory issue slots, plus the final multiplier stage. Requests that cannot stall (pipelined multiplier) are served first. Starvation-guarded requesters come next, then rotating round-robin. The per-requester grant vector feeds back to the issue-stage allocators as `fu_grants` in the same cycle. The per-port select drives the CDB result muxes.

## Interface
- `NUM_REQ`, default 8: number of flattened requesters (ALU, then branch, then mem, then mult).
- `NUM_CDB`, default 2: number of CDB broadcast ports.
- `STARVE_LIMIT`, default 7: consecutive denied cycles after which a requester is starving; must be ≥1.
- `clock` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-low; state reset at a posedge where `reset`==0.
- `flush` input 1: mispredict recovery; active-high.
- `req` input `NUM_REQ`: requester i has a result ready this cycle.
- `urgent` input `NUM_REQ`: requester i cannot stall. Only meaningful with `req[i]`.
- `grant` output `NUM_REQ`: requester i owns a CDB port this cycle.
- `cdb_valid` output `NUM_CDB`: port p carries a result this cycle.
- `cdb_sel` output `NUM_CDB` x `$clog2(NUM_REQ)`: requester index driving port p; 0 when `cdb_valid[p]`==0.
- `urgent_overflow` output 1: sticky; more urgent requests than ports were seen since reset.

## Operation
- State:
  - `rr_ptr` (`$clog2(NUM_REQ)` bits).
  - `wait_cnt[i]` (`$clog2(STARVE_LIMIT+1)` bits each).
  - `urgent_overflow` flag.
- Effective request: `r[i] = req[i]` when `reset`==1 and `flush`==0; otherwise all zero.
- Rotated order: indices `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
- Grant selection is combinational, with at most `NUM_CDB` grants total. Phases fill ports in order, port 0 first:
  - Phase 1: `r[i] & urgent[i]`, ascending index.
  - Phase 2: `r[i] & ~urgent[i] & (wait_cnt[i]==STARVE_LIMIT)`, rotated order.
  - Phase 3: remaining `r[i]`, rotated order.
- A requester is granted at most once per cycle. Unfilled ports have `cdb_valid`=0 and `cdb_sel`=0.
- `wait_cnt[i]` next value:
  - 0 if `grant[i]` or `~r[i]`.
  - otherwise `min(wait_cnt[i]+1, STARVE_LIMIT)`, saturating.
- `rr_ptr` next value:
  - If any grant came from phase 2 or 3: (index of the last such grant in rotated order + 1) mod `NUM_REQ`.
  - Otherwise unchanged. Phase-1 grants never move `rr_ptr`.
- `urgent_overflow` sets when popcount(`r & urgent`) > `NUM_CDB`. The lowest `NUM_CDB` urgent indices are granted; the rest are dropped. The flag clears only on reset, not on `flush`.
- `flush`==1 at a posedge: `rr_ptr`←0, all `wait_cnt`←0; `grant`, `cdb_valid` are 0 that cycle.
- `reset`==0 at a posedge: `rr_ptr`←0, `wait_cnt`←0, `urgent_overflow`←0.
- Outputs while `reset`==0: `grant`=0, `cdb_valid`=0, `cdb_sel`=0.
- Reset value of every output after the reset posedge: all 0.

## Timing
- `grant`, `cdb_valid`, `cdb_sel` are combinational from `req`, `urgent`, `flush`, `reset` and registered state. Zero-cycle latency, so issue allocators clear in the same cycle.
- State updates use that cycle's grants at the next posedge.
- No input-to-state path bypasses the clock.
- No handshake: an ungranted requester must hold `req` itself. The arbiter keeps no memory of requests except `wait_cnt`.
- Simultaneous `flush` and `reset`==0: reset takes effect and outputs are 0.
- Boundary cases:
  - `req`=0 gives no grants and unchanged `rr_ptr`.
  - All `NUM_REQ` requesting with `NUM_CDB`≥`NUM_REQ` grants all.
  - `rr_ptr` wraps from `NUM_REQ-1` to 0.
- Guarantee with `urgent`=0: a continuously requesting requester is granted within `STARVE_LIMIT+ceil(NUM_REQ/NUM_CDB)` cycles.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `req`=8'hFF → `grant`=0, `cdb_valid`=0. First cycle after release with `req`=8'hFF → `grant`=8'h03, `cdb_sel`={1,0}, next `rr_ptr`=2.
- Round-robin wrap: `req`=8'hFF held for 4 cycles → grants 8'h03, 8'h0C, 8'h30, 8'hC0, then 8'h03 again (`rr_ptr` wraps to 0).
- Urgent priority: `rr_ptr`=0, `req`=8'h83, `urgent`=8'h80 → `grant`=8'h81, `cdb_sel[0]`=7, `cdb_sel[1]`=0. Next `rr_ptr`=1 (only index 0 counts). `urgent`=8'hC1 with `req`=8'hC1 → `grant`=8'h41, `urgent_overflow` rises and stays 1 until reset.
- Starvation: `urgent`=8'hC0 and `req`=8'hC4 every cycle → index 2 denied until `wait_cnt[2]`=7, though phase 3 gets no ports. Its grant never comes because phase 1 fills both ports. Then `urgent`=8'h40, `req`=8'h44: index 2 is granted via phase 2 and `wait_cnt[2]`→0.
- Flush mid-stream: `req`=8'hFF, `rr_ptr`=4, assert `flush` one cycle → `grant`=0 that cycle. Next cycle `grant`=8'h03.
- Idle hold: `rr_ptr`=5, `req`=0 for 3 cycles → `rr_ptr` stays 5, all `wait_cnt`=0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester-side bundle of the CDB arbiter.
//   master : functional units / recovery logic (drive req, urgent, flush;
//            observe grant, port mapping and the overflow flag)
//   slave  : cdb_arbiter
// Signals:
//   flush           - mispredict recovery, active-high
//   req[i]          - requester i has a result ready this cycle
//   urgent[i]       - requester i cannot stall (only meaningful with req[i])
//   grant[i]        - requester i owns a CDB port this cycle
//   cdb_valid[p]    - port p carries a result this cycle
//   cdb_sel[p]      - requester index driving port p (0 when port idle)
//   urgent_overflow - sticky: more urgent requests than ports were seen
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 8,
    parameter int NUM_CDB = 2
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                              flush;
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0]                urgent;
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_CDB-1:0]                cdb_valid;
    logic [NUM_CDB-1:0][SEL_W-1:0]     cdb_sel;
    logic                              urgent_overflow;

    modport master (
        output flush, req, urgent,
        input  grant, cdb_valid, cdb_sel, urgent_overflow
    );

    modport slave (
        input  flush, req, urgent,
        output grant, cdb_valid, cdb_sel, urgent_overflow
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: allocates NUM_CDB common-data-bus ports per cycle among
// NUM_REQ functional-unit result requesters.
//   Priority: urgent (ascending index) > starving (rotated) > rest (rotated).
//   Grants and port selects are combinational (same-cycle feedback to the
//   issue allocators); the round-robin pointer, per-requester wait counters
//   and the sticky overflow flag are registered.
// Ports:
//   clock - sole clock, posedge
//   reset - synchronous, active-low
//   bus   - cdb_arbiter_if.slave (flush, req, urgent, grant, cdb_valid,
//           cdb_sel, urgent_overflow)
module cdb_arbiter #(
    parameter int NUM_REQ      = 8,
    parameter int NUM_CDB      = 2,
    parameter int STARVE_LIMIT = 7
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [SEL_W-1:0]                r_rr_ptr;
    logic [NUM_REQ-1:0][CNT_W-1:0]   r_wait_cnt;
    logic                            r_ovf;

    logic [NUM_REQ-1:0]              w_r;
    logic [NUM_REQ-1:0]              w_urg;
    logic [NUM_REQ-1:0]              w_starve;
    logic [NUM_REQ-1:0]              w_grant;
    logic [NUM_CDB-1:0]              w_valid;
    logic [NUM_CDB-1:0][SEL_W-1:0]   w_sel;
    logic                            w_rr_move;
    logic [SEL_W-1:0]                w_rr_next;
    logic                            w_ovf_hit;

    // Reset and flush both mask every request, which forces all outputs
    // to zero and lets the counters see "no request" for free.
    assign w_r   = (reset && !bus.flush) ? bus.req : '0;
    assign w_urg = w_r & bus.urgent;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_starve
        assign w_starve[i] = w_r[i] & ~bus.urgent[i] & (r_wait_cnt[i] == LIMIT);
    end

    assign w_ovf_hit = ($countones(w_urg) > NUM_CDB);

    // Three-phase port fill. max_k tracks the furthest rotated position
    // granted in phases 2/3; urgent grants never move the pointer.
    always_comb begin
        int   nports;
        int   idx;
        int   max_k;
        logic cand;
        w_grant   = '0;
        w_valid   = '0;
        w_sel     = '0;
        nports    = 0;
        max_k     = -1;
        idx       = 0;
        cand      = 1'b0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_urg[i] && nports < NUM_CDB) begin
                w_grant[i]     = 1'b1;
                w_valid[nports] = 1'b1;
                w_sel[nports]   = SEL_W'(i);
                nports         = nports + 1;
            end
        end

        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx  = (int'(r_rr_ptr) + k) % NUM_REQ;
                cand = (ph == 0) ? w_starve[idx] : w_r[idx];
                if (cand && !w_grant[idx] && nports < NUM_CDB) begin
                    w_grant[idx]    = 1'b1;
                    w_valid[nports] = 1'b1;
                    w_sel[nports]   = SEL_W'(idx);
                    nports          = nports + 1;
                    if (k > max_k) max_k = k;
                end
            end
        end

        w_rr_move = (max_k >= 0);
        w_rr_next = SEL_W'((int'(r_rr_ptr) + max_k + 1) % NUM_REQ);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (bus.flush) begin
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_rr_move) r_rr_ptr <= w_rr_next;
            if (w_ovf_hit) r_ovf    <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] || !w_r[i])
                    r_wait_cnt[i] <= '0;
                else if (r_wait_cnt[i] != LIMIT)
                    r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
            end
        end
    end

    assign bus.grant           = w_grant;
    assign bus.cdb_valid       = w_valid;
    assign bus.cdb_sel         = w_sel;
    assign bus.urgent_overflow = r_ovf;
endmodule
